// File: rtl/bmem_if.sv
// bmem_if: burst-memory request/response bundle between a core (master) and a memory (slave)
//  master drives bmem_addr/read/write/wdata; slave returns bmem_ready/raddr/rdata/rvalid
interface bmem_if;
  logic [31:0] bmem_addr;
  logic        bmem_read;
  logic        bmem_write;
  logic [63:0] bmem_wdata;
  logic        bmem_ready;
  logic [31:0] bmem_raddr;
  logic [63:0] bmem_rdata;
  logic        bmem_rvalid;
  modport master (
    output bmem_addr, bmem_read, bmem_write, bmem_wdata,
    input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
  );
  modport slave (
    input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
    output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
  );
endinterface

// File: rtl/bmem_responder.sv
// bmem_responder: burst-memory slave taking 1-cycle line reads and 4-beat write bursts, answering reads as 4 beats after a fixed latency
//  clk, rst (async, active-high); bus: bmem_if.slave; proto_err_o: sticky protocol-violation flag
module bmem_responder #(
  parameter int LINES   = 256,
  parameter int LATENCY = 4,
  parameter int QDEPTH  = 4
) (
  input  logic   clk,
  input  logic   rst,
  bmem_if.slave  bus,
  output logic   proto_err_o
);
  localparam int LW = $clog2(LINES);
  localparam int QW = $clog2(QDEPTH);
  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_WAIT  = 2'd1;
  localparam logic [1:0] R_BURST = 2'd2;
  localparam logic [0:0] W_IDLE  = 1'b0;
  localparam logic [0:0] W_BURST = 1'b1;
  logic [255:0]  mem_q   [LINES];
  logic [26:0]   qaddr_q [QDEPTH];
  logic [255:0]  qdata_q [QDEPTH];
  logic [15:0]   qdue_q  [QDEPTH];
  logic [QW-1:0] wp_q, wp_d, rp_q, rp_d, rp_nx;
  logic [QW:0]   count_q, count_d;
  logic [15:0]   cyc_q, head_diff, next_diff;
  logic [1:0]    rstate_q, rstate_d, rbeat_q, rbeat_d;
  logic [0:0]    wstate_q, wstate_d;
  logic [1:0]    wbeat_q, wbeat_d, wsel_beat;
  logic [LW-1:0] widx_q, widx_d, aidx, wsel_idx;
  logic          err_q, err_d;
  logic          full, ready, wr_start, push, pop, we, head_ok, next_ok, rvalid;
  logic          unused_addr;
  assign unused_addr = ^bus.bmem_addr[4:0];
  always_comb begin
    aidx      = bus.bmem_addr[5 +: LW];
    full      = count_q == (QW+1)'(QDEPTH);
    ready     = !rst && !full && wstate_q == W_IDLE;
    wr_start  = bus.bmem_write && ready;
    push      = bus.bmem_read && ready && !bus.bmem_write;
    pop       = rstate_q == R_BURST && rbeat_q == 2'd3;
    we        = wr_start || (wstate_q == W_BURST && bus.bmem_write);
    wsel_idx  = wstate_q == W_IDLE ? aidx : widx_q;
    wsel_beat = wstate_q == W_IDLE ? 2'd0 : wbeat_q;
    rp_nx     = rp_q + QW'(1);
    // wrap-safe "due reached": sign of the 16-bit difference
    head_diff = cyc_q - qdue_q[rp_q];
    next_diff = cyc_q - qdue_q[rp_nx];
    head_ok   = !head_diff[15];
    next_ok   = !next_diff[15];
    wp_d      = push ? wp_q + QW'(1) : wp_q;
    rp_d      = pop ? rp_nx : rp_q;
    count_d   = count_q + (QW+1)'(push) - (QW+1)'(pop);
    // a late successor starts straight after beat 3 so bursts stay contiguous
    rstate_d  = rstate_q == R_IDLE ? (count_q != '0 ? R_WAIT : R_IDLE)
              : rstate_q == R_WAIT ? (head_ok ? R_BURST : R_WAIT)
              : !pop ? R_BURST
              : (count_q > (QW+1)'(1) && next_ok) ? R_BURST
              : count_d != '0 ? R_WAIT : R_IDLE;
    rbeat_d   = rstate_q == R_BURST ? rbeat_q + 2'd1 : 2'd0;
    wstate_d  = wstate_q == W_IDLE ? (wr_start ? W_BURST : W_IDLE)
              : (bus.bmem_write && wbeat_q != 2'd3 ? W_BURST : W_IDLE);
    wbeat_d   = wstate_q == W_IDLE ? 2'd1 : wbeat_q + 2'd1;
    widx_d    = wstate_q == W_IDLE ? aidx : widx_q;
    err_d     = err_q
              | (bus.bmem_read && (bus.bmem_write || !ready))
              | (wstate_q == W_BURST && !bus.bmem_write)
              | (wstate_q == W_IDLE && bus.bmem_write && !ready);
    rvalid    = rstate_q == R_BURST;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q    <= '0;
      count_q  <= '0;
      wp_q     <= '0;
      rp_q     <= '0;
      rstate_q <= R_IDLE;
      rbeat_q  <= '0;
      wstate_q <= W_IDLE;
      wbeat_q  <= '0;
      widx_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      cyc_q    <= cyc_q + 16'd1;
      count_q  <= count_d;
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      rstate_q <= rstate_d;
      rbeat_q  <= rbeat_d;
      wstate_q <= wstate_d;
      wbeat_q  <= wbeat_d;
      widx_q   <= widx_d;
      err_q    <= err_d;
    end
  end
  // store and queue payload are not reset; the line snapshot fixes read-vs-write ordering
  always_ff @(posedge clk) begin
    if (we) mem_q[wsel_idx][{wsel_beat, 6'd0} +: 64] <= bus.bmem_wdata;
    if (push) begin
      qaddr_q[wp_q] <= bus.bmem_addr[31:5];
      qdata_q[wp_q] <= mem_q[aidx];
      qdue_q[wp_q]  <= cyc_q + 16'(LATENCY);
    end
  end
  assign bus.bmem_ready  = ready;
  assign bus.bmem_rvalid = rvalid;
  assign bus.bmem_raddr  = rvalid ? {qaddr_q[rp_q], 5'b0} : '0;
  assign bus.bmem_rdata  = rvalid ? qdata_q[rp_q][{rbeat_q, 6'd0} +: 64] : '0;
  assign proto_err_o     = err_q;
endmodule

// File: tb/tb_bmem_responder.sv
// tb_bmem_responder: directed self-checking bench for bmem_responder
module tb_bmem_responder;
  localparam int LAT = 4;
  logic clk = 1'b0;
  logic rst;
  logic perr;
  int   errors = 0;
  int   checks = 0;
  bmem_if b();
  bmem_responder #(.LINES(256), .LATENCY(LAT), .QDEPTH(4)) dut (
    .clk(clk), .rst(rst), .bus(b.slave), .proto_err_o(perr)
  );
  always #5 clk = ~clk;
  function automatic logic [63:0] pat(input logic [7:0] t, input int k);
    return {t, 48'h0123_4567_89ab, k[7:0]};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic write_line(input logic [31:0] addr, input logic [7:0] t);
    b.bmem_addr  = addr;
    b.bmem_write = 1'b1;
    for (int k = 0; k < 4; k++) begin
      b.bmem_wdata = pat(t, k);
      tick();
      if (k == 0) chk("wr_busy_ready", 64'(b.bmem_ready), 64'd0);
    end
    b.bmem_write = 1'b0;
    chk("wr_done_ready", 64'(b.bmem_ready), 64'd1);
  endtask
  task automatic read_chk(input string tag, input logic [31:0] addr, input logic [31:0] raddr, input logic [7:0] t);
    int hi;
    hi = 0;
    b.bmem_addr = addr;
    b.bmem_read = 1'b1;
    tick();
    b.bmem_read = 1'b0;
    for (int i = 1; i < LAT; i++) begin
      tick();
      if (b.bmem_rvalid) hi++;
    end
    chk({tag, "_early"}, 64'(hi), 64'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk({tag, "_rvalid"}, 64'(b.bmem_rvalid), 64'd1);
      chk({tag, "_rdata"}, b.bmem_rdata, pat(t, k));
      chk({tag, "_raddr"}, 64'(b.bmem_raddr), 64'(raddr));
    end
    tick();
    chk({tag, "_end"}, 64'(b.bmem_rvalid), 64'd0);
  endtask
  initial begin
    logic [31:0] bb_addr [4];
    logic [7:0]  bb_t [4];
    int hi;
    bb_addr = '{32'h1eceb000, 32'h200, 32'h400, 32'h600};
    bb_t    = '{8'hA1, 8'hC1, 8'hD1, 8'hE1};
    rst = 1'b1;
    b.bmem_addr = '0;
    b.bmem_read = 1'b0;
    b.bmem_write = 1'b0;
    b.bmem_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(b.bmem_ready), 64'd0);
    chk("rst_rvalid", 64'(b.bmem_rvalid), 64'd0);
    chk("rst_rdata", b.bmem_rdata, 64'd0);
    chk("rst_raddr", 64'(b.bmem_raddr), 64'd0);
    chk("rst_perr", 64'(perr), 64'd0);
    rst = 1'b0;
    #1;
    chk("rel_ready", 64'(b.bmem_ready), 64'd1);
    write_line(32'h1eceb000, 8'hA1);
    read_chk("rd_a", 32'h1eceb000, 32'h1eceb000, 8'hA1);
    read_chk("alias_lo", 32'h1eceb01c, 32'h1eceb000, 8'hA1);
    read_chk("alias_wrap", 32'h1eced000, 32'h1eced000, 8'hA1);
    write_line(32'h200, 8'hB1);
    b.bmem_addr = 32'h200;
    b.bmem_read = 1'b1;
    tick();
    b.bmem_read = 1'b0;
    b.bmem_write = 1'b1;
    for (int k = 0; k < 4; k++) begin
      b.bmem_wdata = pat(8'hC1, k);
      tick();
    end
    b.bmem_write = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k != 0) tick();
      chk("old_rvalid", 64'(b.bmem_rvalid), 64'd1);
      chk("old_rdata", b.bmem_rdata, pat(8'hB1, k));
    end
    tick();
    chk("old_end", 64'(b.bmem_rvalid), 64'd0);
    chk("perr_clean", 64'(perr), 64'd0);
    read_chk("new_data", 32'h200, 32'h200, 8'hC1);
    write_line(32'h400, 8'hD1);
    write_line(32'h600, 8'hE1);
    for (int i = 0; i < 4; i++) begin
      b.bmem_addr = bb_addr[i];
      b.bmem_read = 1'b1;
      tick();
    end
    b.bmem_read = 1'b0;
    chk("q_full_ready", 64'(b.bmem_ready), 64'd0);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("bb_rvalid", 64'(b.bmem_rvalid), 64'd1);
      chk("bb_rdata", b.bmem_rdata, pat(bb_t[i/4], i % 4));
      chk("bb_raddr", 64'(b.bmem_raddr), 64'(bb_addr[i/4]));
      if (i == 3) chk("bb_full_ready", 64'(b.bmem_ready), 64'd0);
      if (i == 4) chk("bb_pop_ready", 64'(b.bmem_ready), 64'd1);
    end
    tick();
    chk("bb_end", 64'(b.bmem_rvalid), 64'd0);
    b.bmem_addr = 32'h800;
    b.bmem_read = 1'b1;
    b.bmem_write = 1'b1;
    b.bmem_wdata = pat(8'hF1, 0);
    tick();
    b.bmem_read = 1'b0;
    for (int k = 1; k < 4; k++) begin
      b.bmem_wdata = pat(8'hF1, k);
      tick();
    end
    b.bmem_write = 1'b0;
    chk("rw_perr", 64'(perr), 64'd1);
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (b.bmem_rvalid) hi++;
    end
    chk("rw_no_rvalid", 64'(hi), 64'd0);
    read_chk("rw_write_won", 32'h800, 32'h800, 8'hF1);
    chk("perr_sticky", 64'(perr), 64'd1);
    b.bmem_addr = 32'h200;
    b.bmem_read = 1'b1;
    tick();
    b.bmem_read = 1'b0;
    repeat (LAT + 1) tick();
    chk("mid_rvalid", 64'(b.bmem_rvalid), 64'd1);
    chk("mid_rdata", b.bmem_rdata, pat(8'hC1, 1));
    rst = 1'b1;
    #1;
    chk("arst_rvalid", 64'(b.bmem_rvalid), 64'd0);
    chk("arst_ready", 64'(b.bmem_ready), 64'd0);
    chk("arst_perr", 64'(perr), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("arel_ready", 64'(b.bmem_ready), 64'd1);
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (b.bmem_rvalid) hi++;
    end
    chk("dropped_beats", 64'(hi), 64'd0);
    read_chk("after_rst", 32'h200, 32'h200, 8'hC1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
